// File: rtl/msp430_pkg.sv
// msp430_pkg: fetch FSM states, opcode format constants and decode field bundle.
package msp430_pkg;
  typedef enum logic [2:0] {VEC, FETCH, DECODE, EXT_SRC, EXT_DST, ISSUE} state_t;
  localparam logic [15:0] RST_VEC_DEFAULT = 16'hFFFE;
  localparam logic [3:0]  CG_REG          = 4'd3;
  localparam logic [3:0]  FMT1_MIN        = 4'h4;
  localparam logic [5:0]  FMT2_OP         = 6'b000100;
  localparam logic [2:0]  JMP_OP          = 3'b001;
  typedef struct packed {
    logic [3:0] sa;
    logic [3:0] da;
    logic [1:0] as;
    logic       ad;
    logic       bw;
  } dec_t;
endpackage

// File: rtl/ext_need_dec.sv
// ext_need_dec: field decode and extension-word requirements for one opcode.
module ext_need_dec
  import msp430_pkg::*;
(
  input  logic [15:0] opcode,
  output dec_t        dec,
  output logic        need_src,
  output logic        need_dst
);
  logic fmt1, fmt2, dual;
  always_comb begin
    fmt1     = opcode[15:12] >= FMT1_MIN;
    fmt2     = opcode[15:10] == FMT2_OP;
    dual     = fmt1 | fmt2;
    dec.sa   = fmt1 ? opcode[11:8] : fmt2 ? opcode[3:0] : 4'd0;
    dec.da   = dual ? opcode[3:0] : 4'd0;
    dec.as   = dual ? opcode[5:4] : 2'd0;
    dec.ad   = fmt1 & opcode[7];
    dec.bw   = dual & opcode[6];
    // SA=3 and SA=2 with As=1x are constant generators and carry no word
    need_src = dual && ((dec.as == 2'b01 && dec.sa != CG_REG) ||
                        (dec.as == 2'b11 && dec.sa == 4'd0));
    need_dst = fmt1 & opcode[7];
  end
endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: reset-vector load, instruction/extension fetch, decode and issue.
module ifetch_seq
  import msp430_pkg::*;
#(
  parameter logic [15:0] RST_VEC_ADDR = RST_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic [15:0] reg_PC_in,
  output logic        pc_we,
  output logic [3:0]  SA,
  output logic [3:0]  DA,
  output logic [1:0]  As,
  output logic        Ad,
  output logic        BW,
  output logic [15:0] opcode,
  output logic [15:0] src_ext,
  output logic [15:0] dst_ext,
  output logic        instr_valid,
  input  logic        instr_ready
);
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d, opcode_q, opcode_d;
  logic [15:0] src_ext_q, src_ext_d, dst_ext_q, dst_ext_d;
  logic        req_q, req_d, pc_we_q, pc_we_d, valid_q, valid_d, discard_q, discard_d;
  logic        need_src, need_dst, rd_state, rd_done;
  dec_t        dec;

  ext_need_dec u_dec (.opcode(opcode_q), .dec(dec), .need_src(need_src), .need_dst(need_dst));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    opcode_d  = opcode_q;
    src_ext_d = src_ext_q;
    dst_ext_d = dst_ext_q;
    req_d     = req_q;
    valid_d   = valid_q;
    discard_d = discard_q;
    pc_we_d   = 1'b0;
    rd_state  = state_q == VEC || state_q == FETCH || state_q == EXT_SRC || state_q == EXT_DST;
    rd_done   = req_q && mem_rdy;
    if (discard_q) begin
      if (rd_done) begin
        req_d     = 1'b0;
        discard_d = 1'b0;
      end
    end else if (rd_state && !req_q) begin
      req_d  = 1'b1;
      addr_d = state_q == VEC ? RST_VEC_ADDR : pc_q;
    end else if (rd_state && rd_done) begin
      req_d   = 1'b0;
      pc_we_d = 1'b1;
      pc_d    = state_q == VEC ? (mem_rdata & 16'hFFFE) : pc_q + 16'd2;
      state_d = state_q == VEC ? FETCH : state_q == FETCH ? DECODE :
                (state_q == EXT_SRC && need_dst) ? EXT_DST : ISSUE;
      valid_d = state_d == ISSUE;
      if (state_q == FETCH) begin
        opcode_d  = mem_rdata;
        src_ext_d = 16'd0;
        dst_ext_d = 16'd0;
      end
      if (state_q == EXT_SRC) src_ext_d = mem_rdata;
      if (state_q == EXT_DST) dst_ext_d = mem_rdata;
    end else if (state_q == DECODE) begin
      state_d = need_src ? EXT_SRC : need_dst ? EXT_DST : ISSUE;
      valid_d = !(need_src || need_dst);
    end else if (state_q == ISSUE && instr_ready) begin
      valid_d = 1'b0;
      state_d = FETCH;
    end
    // a redirect never aborts a read in flight; its data is just thrown away
    if (pc_load && state_q != VEC) begin
      pc_d    = pc_load_val & 16'hFFFE;
      pc_we_d = 1'b1;
      valid_d = 1'b0;
      state_d = FETCH;
      if (!req_q) req_d = 1'b0;
      else if (!rd_done) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= VEC;
      pc_q      <= '0;
      addr_q    <= '0;
      opcode_q  <= '0;
      src_ext_q <= '0;
      dst_ext_q <= '0;
      req_q     <= 1'b0;
      pc_we_q   <= 1'b0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      opcode_q  <= opcode_d;
      src_ext_q <= src_ext_d;
      dst_ext_q <= dst_ext_d;
      req_q     <= req_d;
      pc_we_q   <= pc_we_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign reg_PC_in   = pc_q;
  assign pc_we       = pc_we_q;
  assign instr_valid = valid_q;
  assign opcode      = opcode_q;
  assign src_ext     = src_ext_q;
  assign dst_ext     = dst_ext_q;
  assign SA          = dec.sa;
  assign DA          = dec.da;
  assign As          = dec.as;
  assign Ad          = dec.ad;
  assign BW          = dec.bw;
endmodule

// File: tb/tb_ifetch_seq.sv
// tb_ifetch_seq: directed fetch/decode/issue scenarios against a small word memory.
module tb_ifetch_seq;
  import msp430_pkg::*;
  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_req, mem_rdy, pc_load = 1'b0, pc_we, Ad, BW, instr_valid, instr_ready = 1'b0;
  logic [15:0] mem_addr, mem_rdata, pc_load_val = '0, reg_PC_in, opcode, src_ext, dst_ext;
  logic [3:0]  SA, DA;
  logic [1:0]  As;
  logic        rdy_en = 1'b1;
  int          n_chk = 0, n_fail = 0, acc_cnt = 0, acc0;

  localparam logic [15:0] MADDR [8] = '{16'hFFFE, 16'hC000, 16'hC002, 16'hC004,
                                        16'hC006, 16'hC008, 16'hC00A, 16'hD000};
  localparam logic [15:0] MDATA [8] = '{16'hC000, 16'h4506, 16'h40B2, 16'h1234,
                                        16'h0200, 16'h4316, 16'h4506, 16'h4316};

  ifetch_seq dut (.clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .reg_PC_in(reg_PC_in), .pc_we(pc_we), .SA(SA), .DA(DA), .As(As), .Ad(Ad), .BW(BW),
    .opcode(opcode), .src_ext(src_ext), .dst_ext(dst_ext), .instr_valid(instr_valid),
    .instr_ready(instr_ready));

  always #5 clk = ~clk;
  assign mem_rdy = rdy_en;
  always_comb begin
    mem_rdata = 16'h0;
    for (int i = 0; i < 8; i++) if (MADDR[i] == mem_addr) mem_rdata = MDATA[i];
  end
  always @(posedge clk) if (instr_valid && instr_ready) acc_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    chk("valid_timeout", {15'd0, instr_valid}, 16'd1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("req_timeout", {15'd0, mem_req}, 16'd1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_we", {15'd0, pc_we}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_pc", reg_PC_in, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    chk("vec_req", {15'd0, mem_req}, 16'd1);
    chk("vec_addr", mem_addr, 16'hFFFE);
    @(negedge clk);
    chk("vec_we", {15'd0, pc_we}, 16'd1);
    chk("vec_pc", reg_PC_in, 16'hC000);
    @(negedge clk);
    chk("fetch0_addr", mem_addr, 16'hC000);
    chk("fetch0_we", {15'd0, pc_we}, 16'd0);
    // register-to-register
    wait_valid();
    chk("rr_op", opcode, 16'h4506);
    chk("rr_sa", {12'd0, SA}, 16'd5);
    chk("rr_da", {12'd0, DA}, 16'd6);
    chk("rr_as", {14'd0, As}, 16'd0);
    chk("rr_adbw", {14'd0, Ad, BW}, 16'd0);
    chk("rr_src", src_ext, 16'h0);
    chk("rr_dst", dst_ext, 16'h0);
    accept();
    wait_req();
    chk("rr_next", mem_addr, 16'hC002);
    // two extension words
    wait_valid();
    chk("x2_src", src_ext, 16'h1234);
    chk("x2_dst", dst_ext, 16'h0200);
    chk("x2_as", {14'd0, As}, 16'd3);
    chk("x2_ad", {15'd0, Ad}, 16'd1);
    chk("x2_da", {12'd0, DA}, 16'd2);
    chk("x2_sa", {12'd0, SA}, 16'd0);
    accept();
    rdy_en = 1'b0;
    wait_req();
    chk("x2_next", mem_addr, 16'hC008);
    // three wait-state cycles on the fetch of the constant-generator instruction
    for (int i = 0; i < 3; i++) begin
      chk("ws_addr", mem_addr, 16'hC008);
      chk("ws_req", {15'd0, mem_req}, 16'd1);
      if (i < 2) @(negedge clk);
    end
    rdy_en = 1'b1;
    wait_valid();
    chk("cg_op", opcode, 16'h4316);
    chk("cg_as", {14'd0, As}, 16'd1);
    chk("cg_sa", {12'd0, SA}, 16'd3);
    chk("cg_src", src_ext, 16'h0);
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {15'd0, instr_valid}, 16'd1);
      chk("stall_op", opcode, 16'h4316);
      chk("stall_da", {12'd0, DA}, 16'd6);
      @(negedge clk);
    end
    accept();
    rdy_en = 1'b0;
    chk("stall_acc", 16'(acc_cnt - acc0), 16'd1);
    chk("stall_drop", {15'd0, instr_valid}, 16'd0);
    // redirect while the fetch at C00A is outstanding
    wait_req();
    chk("cg_next", mem_addr, 16'hC00A);
    pc_load = 1'b1;
    pc_load_val = 16'hD001;
    @(negedge clk);
    pc_load = 1'b0;
    chk("rd_we", {15'd0, pc_we}, 16'd1);
    chk("rd_pc", reg_PC_in, 16'hD000);
    chk("rd_hold", mem_addr, 16'hC00A);
    chk("rd_req", {15'd0, mem_req}, 16'd1);
    rdy_en = 1'b1;
    @(negedge clk);
    chk("rd_done", {15'd0, mem_req}, 16'd0);
    @(negedge clk);
    chk("rd_addr", mem_addr, 16'hD000);
    wait_valid();
    chk("rd_op", opcode, 16'h4316);
    // redirect coinciding with acceptance
    acc0 = acc_cnt;
    pc_load = 1'b1;
    pc_load_val = 16'hC000;
    accept();
    pc_load = 1'b0;
    chk("la_acc", 16'(acc_cnt - acc0), 16'd1);
    chk("la_pc", reg_PC_in, 16'hC000);
    chk("la_we", {15'd0, pc_we}, 16'd1);
    wait_req();
    chk("la_addr", mem_addr, 16'hC000);
    // asynchronous reset mid-read
    #2 rst = 1'b0;
    #1;
    chk("ar_req", {15'd0, mem_req}, 16'd0);
    chk("ar_pc", reg_PC_in, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_vec", mem_addr, 16'hFFFE);
    chk("ar_vreq", {15'd0, mem_req}, 16'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
